// File: rtl/ysyx_24090012_lsu_wb_tx.sv
// LSU-to-WBU transmit buffer: 2-entry FIFO that formats load data at enqueue
// and presents the head entry to the write-back unit.
module ysyx_24090012_lsu_wb_tx #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_inst,
    input  logic [DATA_WIDTH-1:0] in_next_pc,
    input  logic [63:0]           in_num,
    input  logic [DATA_WIDTH-1:0] in_addr,
    input  logic [DATA_WIDTH-1:0] in_alu_result,
    input  logic [DATA_WIDTH-1:0] in_mem_rdata,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] lsu_to_wbu_inst,
    output logic [DATA_WIDTH-1:0] next_pc,
    output logic [63:0]           num,
    output logic [DATA_WIDTH-1:0] sim_lsu_addr,
    output logic [1:0]            occupancy
);

    logic [DATA_WIDTH-1:0] wdata_q   [2];
    logic [DATA_WIDTH-1:0] inst_q    [2];
    logic [DATA_WIDTH-1:0] next_pc_q [2];
    logic [63:0]           num_q     [2];
    logic [DATA_WIDTH-1:0] addr_q    [2];

    logic                  wptr;
    logic                  rptr;
    logic [1:0]            occ;
    logic                  enq;
    logic                  deq;
    logic [7:0]            byte_lane;
    logic [15:0]           half_lane;
    logic [DATA_WIDTH-1:0] load_data;
    logic [DATA_WIDTH-1:0] enq_wdata;

    assign in_ready  = (occ != 2'd2);
    assign rd_valid  = (occ != 2'd0);
    assign occupancy = occ;
    assign enq       = in_valid && in_ready;
    assign deq       = rd_valid && rd_ready;

    assign wdata           = wdata_q[rptr];
    assign lsu_to_wbu_inst = inst_q[rptr];
    assign next_pc         = next_pc_q[rptr];
    assign num             = num_q[rptr];
    assign sim_lsu_addr    = addr_q[rptr];

    // Misaligned halfword/word loads silently use the aligned lanes.
    always_comb begin
        byte_lane = 8'd0;
        half_lane = in_addr[1] ? in_mem_rdata[31:16] : in_mem_rdata[15:0];
        load_data = in_mem_rdata;
        unique case (in_addr[1:0])
            2'd0: byte_lane = in_mem_rdata[7:0];
            2'd1: byte_lane = in_mem_rdata[15:8];
            2'd2: byte_lane = in_mem_rdata[23:16];
            2'd3: byte_lane = in_mem_rdata[31:24];
            default: byte_lane = 8'd0;
        endcase
        unique case (in_inst[14:12])
            3'b000: load_data = {{(DATA_WIDTH-8){byte_lane[7]}}, byte_lane};
            3'b001: load_data = {{(DATA_WIDTH-16){half_lane[15]}}, half_lane};
            3'b100: load_data = {{(DATA_WIDTH-8){1'b0}}, byte_lane};
            3'b101: load_data = {{(DATA_WIDTH-16){1'b0}}, half_lane};
            default: load_data = in_mem_rdata;
        endcase
        enq_wdata = (in_inst[6:0] == 7'b0000011) ? load_data : in_alu_result;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                wdata_q[i]   <= '0;
                inst_q[i]    <= '0;
                next_pc_q[i] <= '0;
                num_q[i]     <= '0;
                addr_q[i]    <= '0;
            end
            wptr <= 1'b0;
            rptr <= 1'b0;
            occ  <= 2'd0;
        end else if (flush) begin
            wptr <= 1'b0;
            rptr <= 1'b0;
            occ  <= 2'd0;
        end else begin
            if (enq) begin
                wdata_q[wptr]   <= enq_wdata;
                inst_q[wptr]    <= in_inst;
                next_pc_q[wptr] <= in_next_pc;
                num_q[wptr]     <= in_num;
                addr_q[wptr]    <= in_addr;
                wptr            <= wptr + 1'b1;
            end
            if (deq) begin
                rptr <= rptr + 1'b1;
            end
            if (enq && !deq) begin
                occ <= occ + 2'd1;
            end else if (!enq && deq) begin
                occ <= occ - 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_24090012_lsu_wb_tx.sv
// Directed testbench for the LSU-to-WBU transmit buffer.
module tb_ysyx_24090012_lsu_wb_tx;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_inst = '0;
    logic [31:0] in_next_pc = '0;
    logic [63:0] in_num = '0;
    logic [31:0] in_addr = '0;
    logic [31:0] in_alu_result = '0;
    logic [31:0] in_mem_rdata = '0;
    logic        rd_valid;
    logic        rd_ready = 1'b0;
    logic [31:0] wdata;
    logic [31:0] lsu_to_wbu_inst;
    logic [31:0] next_pc;
    logic [63:0] num;
    logic [31:0] sim_lsu_addr;
    logic [1:0]  occupancy;

    int checks = 0;
    int failures = 0;

    ysyx_24090012_lsu_wb_tx #(.DATA_WIDTH(32)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_next_pc(in_next_pc), .in_num(in_num),
        .in_addr(in_addr), .in_alu_result(in_alu_result),
        .in_mem_rdata(in_mem_rdata),
        .rd_valid(rd_valid), .rd_ready(rd_ready),
        .wdata(wdata), .lsu_to_wbu_inst(lsu_to_wbu_inst),
        .next_pc(next_pc), .num(num), .sim_lsu_addr(sim_lsu_addr),
        .occupancy(occupancy)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_in(input logic [31:0] inst, input logic [31:0] addr,
                          input logic [31:0] alu, input logic [31:0] rdata,
                          input logic [63:0] n);
        in_valid = 1'b1;
        in_inst = inst;
        in_addr = addr;
        in_alu_result = alu;
        in_mem_rdata = rdata;
        in_num = n;
        in_next_pc = 32'h8000_0000 + n[31:0] * 4;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks++;
        if (rd_valid !== 1'b0) begin
            failures++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid);
        end
        checks++;
        if (wdata !== 32'h0 || num !== 64'h0 || lsu_to_wbu_inst !== 32'h0) begin
            failures++; $display("FAIL reset_fields got=%h/%h exp=0", wdata, num);
        end
        checks++;
        if (occupancy !== 2'd0 || in_ready !== 1'b1) begin
            failures++; $display("FAIL reset_occ got=%0d/%b exp=0/1", occupancy, in_ready);
        end
    endtask

    task automatic test_pass_through();
        rd_ready = 1'b1;
        set_in(32'h0050_0093, 32'h0, 32'd5, 32'hDEAD_BEEF, 64'd7);
        tick();
        in_valid = 1'b0;
        checks++;
        if (rd_valid !== 1'b1 || wdata !== 32'd5) begin
            failures++; $display("FAIL pass_wdata got=%b/%h exp=1/5", rd_valid, wdata);
        end
        checks++;
        if (lsu_to_wbu_inst !== 32'h0050_0093 || num !== 64'd7) begin
            failures++; $display("FAIL pass_inst got=%h/%0d exp=00500093/7", lsu_to_wbu_inst, num);
        end
        checks++;
        if (next_pc !== 32'h8000_001C || sim_lsu_addr !== 32'h0) begin
            failures++; $display("FAIL pass_pc got=%h/%h exp=8000001c/0", next_pc, sim_lsu_addr);
        end
        tick();
        checks++;
        if (occupancy !== 2'd0 || rd_valid !== 1'b0) begin
            failures++; $display("FAIL pass_drain got=%0d exp=0", occupancy);
        end
    endtask

    task automatic test_load_extract();
        logic [31:0] insts [7];
        logic [31:0] addrs [7];
        logic [31:0] exps  [7];
        insts[0] = 32'h0000_0003; addrs[0] = 32'h8000_0003; exps[0] = 32'hFFFF_FF80;
        insts[1] = 32'h0000_5003; addrs[1] = 32'h8000_0002; exps[1] = 32'h0000_80FF;
        insts[2] = 32'h0000_1003; addrs[2] = 32'h8000_0001; exps[2] = 32'h0000_1234;
        insts[3] = 32'h0000_1003; addrs[3] = 32'h8000_0003; exps[3] = 32'hFFFF_80FF;
        insts[4] = 32'h0000_4003; addrs[4] = 32'h8000_0001; exps[4] = 32'h0000_0012;
        insts[5] = 32'h0000_2003; addrs[5] = 32'h8000_0003; exps[5] = 32'h80FF_1234;
        insts[6] = 32'h0000_0013; addrs[6] = 32'h8000_0000; exps[6] = 32'h0000_ABCD;
        rd_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            set_in(insts[i], addrs[i], 32'h0000_ABCD, 32'h80FF_1234, 64'(100 + i));
            tick();
            in_valid = 1'b0;
            checks++;
            if (wdata !== exps[i] || sim_lsu_addr !== addrs[i]) begin
                failures++;
                $display("FAIL load_%0d got=%h exp=%h", i, wdata, exps[i]);
            end
        end
        tick();
        checks++;
        if (occupancy !== 2'd0) begin
            failures++; $display("FAIL load_drain got=%0d exp=0", occupancy);
        end
    endtask

    task automatic test_backpressure();
        rd_ready = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            set_in(32'h0000_0013, 32'h0, 32'(i), 32'h0, 64'(i));
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (occupancy !== 2'd2 || in_ready !== 1'b0) begin
            failures++; $display("FAIL bp_full got=%0d/%b exp=2/0", occupancy, in_ready);
        end
        checks++;
        if (rd_valid !== 1'b1 || num !== 64'd1) begin
            failures++; $display("FAIL bp_hold got=%0d exp=1", num);
        end
        rd_ready = 1'b1;
        tick();
        checks++;
        if (num !== 64'd2 || occupancy !== 2'd1) begin
            failures++; $display("FAIL bp_second got=%0d/%0d exp=2/1", num, occupancy);
        end
        tick();
        checks++;
        if (rd_valid !== 1'b0 || occupancy !== 2'd0) begin
            failures++; $display("FAIL bp_no_third got=%b/%0d exp=0/0", rd_valid, num);
        end
    endtask

    task automatic test_back_to_back();
        rd_ready = 1'b1;
        set_in(32'h0000_0013, 32'h0, 32'd10, 32'h0, 64'd10);
        tick();
        checks++;
        if (num !== 64'd10 || occupancy !== 2'd1) begin
            failures++; $display("FAIL b2b_first got=%0d exp=10", num);
        end
        for (int i = 11; i <= 13; i++) begin
            set_in(32'h0000_0013, 32'h0, 32'(i), 32'h0, 64'(i));
            tick();
            checks++;
            if (num !== 64'(i) || occupancy !== 2'd1 || wdata !== 32'(i)) begin
                failures++;
                $display("FAIL b2b_%0d got=%0d/%0d exp=%0d/1", i, num, occupancy, i);
            end
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (occupancy !== 2'd0) begin
            failures++; $display("FAIL b2b_drain got=%0d exp=0", occupancy);
        end
    endtask

    task automatic test_flush();
        rd_ready = 1'b0;
        set_in(32'h0000_0013, 32'h0, 32'd20, 32'h0, 64'd20);
        tick();
        set_in(32'h0000_0013, 32'h0, 32'd21, 32'h0, 64'd21);
        tick();
        flush = 1'b1;
        rd_ready = 1'b1;
        set_in(32'h0000_0013, 32'h0, 32'd22, 32'h0, 64'd22);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (occupancy !== 2'd0 || rd_valid !== 1'b0) begin
            failures++; $display("FAIL flush_empty got=%0d/%b exp=0/0", occupancy, rd_valid);
        end
        rd_ready = 1'b0;
        set_in(32'h0000_0013, 32'h0, 32'd23, 32'h0, 64'd23);
        tick();
        in_valid = 1'b0;
        checks++;
        if (rd_valid !== 1'b1 || num !== 64'd23 || occupancy !== 2'd1) begin
            failures++; $display("FAIL flush_next got=%0d exp=23", num);
        end
        rd_ready = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid();
        rd_ready = 1'b0;
        set_in(32'h0000_0013, 32'h4, 32'd30, 32'h0, 64'd30);
        tick();
        set_in(32'h0000_0013, 32'h4, 32'd31, 32'h0, 64'd31);
        tick();
        in_valid = 1'b0;
        checks++;
        if (occupancy !== 2'd2) begin
            failures++; $display("FAIL rmid_fill got=%0d exp=2", occupancy);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (rd_valid !== 1'b0 || occupancy !== 2'd0) begin
            failures++; $display("FAIL rmid_valid got=%b/%0d exp=0/0", rd_valid, occupancy);
        end
        checks++;
        if (wdata !== 32'h0 || lsu_to_wbu_inst !== 32'h0 || next_pc !== 32'h0
            || num !== 64'h0 || sim_lsu_addr !== 32'h0) begin
            failures++;
            $display("FAIL rmid_fields got=%h/%h/%h/%0d/%h exp=0",
                     wdata, lsu_to_wbu_inst, next_pc, num, sim_lsu_addr);
        end
        tick();
        checks++;
        if (in_ready !== 1'b1) begin
            failures++; $display("FAIL rmid_ready got=%b exp=1", in_ready);
        end
    endtask

    initial begin
        test_reset();
        test_pass_through();
        test_load_extract();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ysyx_24090012_lsu_wb_tx.md
YSYX_24090012_LSU_WB_TX -- requirements
Module: ysyx_24090012_lsu_wb_tx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of result, address and instruction words.
REQ-002 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port flush  input  1  synchronous drop of all buffered entries.
REQ-005 SHALL have port in_valid  input  1  LSU result valid.
REQ-006 SHALL have port in_ready  output  1  buffer can accept this cycle.
REQ-007 SHALL have port in_inst  input  32  instruction word.
REQ-008 SHALL have port in_next_pc  input  32  next PC of instruction.
REQ-009 SHALL have port in_num  input  64  instruction sequence number.
REQ-010 SHALL have port in_addr  input  32  LSU access address (0 if none).
REQ-011 SHALL have port in_alu_result  input  32  EXU result for non-load instructions.
REQ-012 SHALL have port in_mem_rdata  input  32  raw aligned memory word for loads.
REQ-013 SHALL have port rd_valid  output  1  write request to WBU.
REQ-014 SHALL have port rd_ready  input  1  WBU accepts request.
REQ-015 SHALL have ports wdata 32, lsu_to_wbu_inst 32, next_pc 32, num 64, sim_lsu_addr 32  outputs  head-entry fields toward WBU.
REQ-016 SHALL have port occupancy  output  2  entries held (0..2).

Function
REQ-017 SHALL hold a 2-entry FIFO; each entry = {wdata, inst, next_pc, num, addr}.
REQ-018 SHALL enqueue when in_valid && in_ready; in_ready = (occupancy != 2), no combinational dependence on rd_ready.
REQ-019 SHALL dequeue when rd_valid && rd_ready; rd_valid = (occupancy != 0).
REQ-020 SHALL drive all WBU outputs from the head entry registers; values stable while rd_valid && !rd_ready.
REQ-021 SHALL make an entry accepted in cycle N visible at rd_valid in cycle N+1 (1-cycle latency, empty buffer).
REQ-022 SHALL allow simultaneous enqueue and dequeue at occupancy 1: occupancy stays 1, new entry becomes head next cycle.
REQ-023 SHALL preserve FIFO order; read/write pointers 1 bit each, wrap 1->0.
REQ-024 SHALL compute stored wdata at enqueue: opcode in_inst[6:0] != 7'b0000011 -> in_alu_result.
REQ-025 SHALL for loads select by funct3 in_inst[14:12] and in_addr[1:0]: 000 lb sign-extended byte lane addr[1:0]; 001 lh sign-extended halfword lane addr[1]; 010 lw full word; 100 lbu zero-extended byte; 101 lhu zero-extended halfword; other funct3 -> full word.
REQ-026 SHALL ignore addr[0] for halfword loads and addr[1:0] for lw (no misalignment trap).
REQ-027 SHALL on flush set occupancy to 0 and both pointers to 0 next cycle; flush overrides same-cycle enqueue and dequeue.
REQ-028 SHALL ignore in_valid, in_* data when in_ready is 0; SHALL not drop or duplicate entries under back-pressure.

Reset
REQ-029 SHALL on reset set occupancy 0, pointers 0, all entry fields 0, giving rd_valid=0, wdata=0, lsu_to_wbu_inst=0, next_pc=0, num=0, sim_lsu_addr=0 in the following cycle.
REQ-030 SHALL give in_ready=1 in the first cycle after reset deasserts.
REQ-031 SHALL give reset priority over flush and handshakes; reset mid-transfer discards all entries.

Verification
REQ-032 Single pass-through: addi inst 0x00500093, alu 5, rd_ready=1 -> next cycle rd_valid=1, wdata=5, inst=0x00500093; following cycle occupancy 0.
REQ-033 Load extract: lb (funct3 000), addr 0x80000003, mem_rdata 0x80FF1234 -> wdata 0xFFFFFF80; lhu addr 0x80000002 same word -> 0x000080FF.
REQ-034 Back-pressure: rd_ready=0, push num=1,2,3 -> occupancy 2, in_ready=0, num=1 held; release rd_ready -> num 1 then 2 delivered, num 3 never seen.
REQ-035 Simultaneous push/pop at occupancy 1 with rd_ready=1 for 4 cycles, num 10..13 -> outputs 10,11,12,13 in order, occupancy constant 1.
REQ-036 Flush with occupancy 2 and in_valid=1 same cycle -> next cycle occupancy 0, rd_valid=0; next push delivered with its own num.
REQ-037 Reset asserted with occupancy 2 -> next cycle rd_valid=0, all WBU outputs 0, in_ready=1 after release.
